// File: rtl/rtc_bcd_core.sv
// rtc_bcd_core: 1 Hz divider, BCD hh:mm:ss timekeeping, 12/24 h display and N alarm channels.
module rtc_bcd_core #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned N_ALARM    = 2,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_load,
    input  logic [7:0]             set_hour,
    input  logic [7:0]             set_min,
    input  logic [7:0]             set_sec,
    input  logic                   mode_12h,
    input  logic [N_ALARM-1:0]     alarm_en,
    input  logic [16*N_ALARM-1:0]  alarm_time,
    input  logic                   snooze,
    input  logic                   stop,
    output logic [7:0]             hour,
    output logic [7:0]             min,
    output logic [7:0]             sec,
    output logic                   pm,
    output logic                   tick_1s,
    output logic [N_ALARM-1:0]     ring,
    output logic                   set_err
);

    localparam int unsigned DIV_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int unsigned CNT_W     = $clog2(SNZ_TICKS + RING_SEC);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SEC - 1);
    localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNZ_TICKS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_e;

    logic [DIV_W-1:0] div_q;
    logic [7:0]       hour_q, min_q, sec_q;
    logic             tick_q, err_q;
    logic [7:0]       hour_d, min_d, sec_d;
    logic             wrap, load_ok;
    logic [N_ALARM-1:0] match;
    logic [N_ALARM-1:0] ring_q;
    state_e           state_q [N_ALARM];
    logic [CNT_W-1:0] cnt_q   [N_ALARM];
    logic [4:0]       h_bin, h_sub;
    logic [7:0]       hour_pm, hour_disp;

    // BCD increment that wraps to 00 after the given last value
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // One-second carry chain and load validation
    always_comb begin
        wrap    = (div_q == DIV_LAST);
        sec_d   = bcd_inc(sec_q, 8'h59);
        min_d   = (sec_q == 8'h59) ? bcd_inc(min_q, 8'h59) : min_q;
        hour_d  = (sec_q == 8'h59 && min_q == 8'h59) ? bcd_inc(hour_q, 8'h23) : hour_q;
        load_ok = (set_hour[3:0] <= 4'd9) && (set_hour[7:4] <= 4'd9) &&
                  (set_min[3:0]  <= 4'd9) && (set_min[7:4]  <= 4'd9) &&
                  (set_sec[3:0]  <= 4'd9) && (set_sec[7:4]  <= 4'd9) &&
                  (set_hour <= 8'h23) && (set_min <= 8'h59) && (set_sec <= 8'h59);
    end

    // Divider, time registers, tick and load-error pulses; an accepted load beats the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            hour_q <= 8'h00;
            min_q  <= 8'h00;
            sec_q  <= 8'h00;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            err_q  <= 1'b0;
            if (set_load && load_ok) begin
                div_q  <= '0;
                hour_q <= set_hour;
                min_q  <= set_min;
                sec_q  <= set_sec;
            end else begin
                if (set_load)
                    err_q <= 1'b1;
                if (wrap) begin
                    div_q  <= '0;
                    hour_q <= hour_d;
                    min_q  <= min_d;
                    sec_q  <= sec_d;
                    tick_q <= 1'b1;
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end
        end
    end

    // Alarm match against hh:mm:00 of each channel
    always_comb begin
        for (int i = 0; i < int'(N_ALARM); i++) begin
            match[i] = (alarm_time[16*i+8 +: 8] == hour_q) &&
                       (alarm_time[16*i   +: 8] == min_q) &&
                       (sec_q == 8'h00);
        end
    end

    // Per-channel IDLE/RING/SNOOZE machine; disable and stop dominate everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_q <= '0;
            for (int i = 0; i < int'(N_ALARM); i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_ALARM); i++) begin
                if (!alarm_en[i] || stop) begin
                    state_q[i] <= ST_IDLE;
                    cnt_q[i]   <= '0;
                    ring_q[i]  <= 1'b0;
                end else begin
                    case (state_q[i])
                        ST_IDLE: begin
                            if (tick_q && match[i]) begin
                                state_q[i] <= ST_RING;
                                cnt_q[i]   <= '0;
                                ring_q[i]  <= 1'b1;
                            end
                        end
                        ST_RING: begin
                            if (snooze) begin
                                state_q[i] <= ST_SNOOZE;
                                cnt_q[i]   <= '0;
                                ring_q[i]  <= 1'b0;
                            end else if (tick_q) begin
                                if (cnt_q[i] == RING_LAST) begin
                                    state_q[i] <= ST_IDLE;
                                    cnt_q[i]   <= '0;
                                    ring_q[i]  <= 1'b0;
                                end else begin
                                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                                end
                            end
                        end
                        ST_SNOOZE: begin
                            if (tick_q) begin
                                if (cnt_q[i] == SNZ_LAST) begin
                                    state_q[i] <= ST_RING;
                                    cnt_q[i]   <= '0;
                                    ring_q[i]  <= 1'b1;
                                end else begin
                                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                                end
                            end
                        end
                        default: begin
                            state_q[i] <= ST_IDLE;
                            cnt_q[i]   <= '0;
                            ring_q[i]  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // 12-hour view of the internal 24-hour BCD hour
    always_comb begin
        h_bin = 5'(hour_q[7:4]) * 5'd10 + 5'(hour_q[3:0]);
        h_sub = h_bin - 5'd12;
        if (h_sub >= 5'd10)
            hour_pm = {4'd1, 4'(h_sub - 5'd10)};
        else
            hour_pm = {4'd0, h_sub[3:0]};
        if (!mode_12h)
            hour_disp = hour_q;
        else if (hour_q == 8'h00)
            hour_disp = 8'h12;
        else if (hour_q <= 8'h12)
            hour_disp = hour_q;
        else
            hour_disp = hour_pm;
    end

    assign hour    = hour_disp;
    assign min     = min_q;
    assign sec     = sec_q;
    assign pm      = (hour_q >= 8'h12);
    assign tick_1s = tick_q;
    assign ring    = ring_q;
    assign set_err = err_q;

endmodule

// File: tb/tb_rtc_bcd_core.sv
// Directed bench for rtc_bcd_core with TICK_DIV=4, RING_SEC=3, SNOOZE_MIN=1.
module tb_rtc_bcd_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        set_load = 1'b0;
    logic [7:0]  set_hour = 8'h00, set_min = 8'h00, set_sec = 8'h00;
    logic        mode_12h = 1'b0;
    logic [1:0]  alarm_en = 2'b00;
    logic [31:0] alarm_time = {16'h0800, 16'h0730};
    logic        snooze = 1'b0, stop = 1'b0;
    logic [7:0]  hour, min, sec;
    logic        pm, tick_1s, set_err;
    logic [1:0]  ring;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rtc_bcd_core #(
        .TICK_DIV(4), .N_ALARM(2), .RING_SEC(3), .SNOOZE_MIN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .set_load(set_load),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .mode_12h(mode_12h), .alarm_en(alarm_en), .alarm_time(alarm_time),
        .snooze(snooze), .stop(stop),
        .hour(hour), .min(min), .sec(sec), .pm(pm),
        .tick_1s(tick_1s), .ring(ring), .set_err(set_err)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge right after the load edge
    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_hour = h; set_min = m; set_sec = s; set_load = 1'b1;
        @(negedge clk);
        set_load = 1'b0;
    endtask

    task automatic test_reset;
        cyc(2);
        checks++; if ({hour, min, sec} !== 24'h000000) begin errors++; $display("FAIL reset_time got %h want 000000", {hour, min, sec}); end
        checks++; if ({tick_1s, ring, set_err, pm} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {tick_1s, ring, set_err, pm}); end
        mode_12h = 1'b1; #1;
        checks++; if (hour !== 8'h12) begin errors++; $display("FAIL reset_hour12 got %h want 12", hour); end
        mode_12h = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        cyc(3);
        checks++; if (tick_1s !== 1'b0) begin errors++; $display("FAIL reset_tick_early got %b want 0", tick_1s); end
        cyc(1);
        checks++; if (tick_1s !== 1'b1 || sec !== 8'h01) begin errors++; $display("FAIL reset_first_tick got tick=%b sec=%h want 1/01", tick_1s, sec); end
    endtask

    task automatic test_wrap;
        mode_12h = 1'b1;
        do_load(8'h23, 8'h59, 8'h58);
        checks++; if (hour !== 8'h11 || pm !== 1'b1 || sec !== 8'h58) begin errors++; $display("FAIL wrap_load got %h:%h pm=%b want 11:58 pm=1", hour, sec, pm); end
        cyc(3);
        checks++; if (tick_1s !== 1'b0) begin errors++; $display("FAIL wrap_tick_early got %b want 0", tick_1s); end
        cyc(1);
        checks++; if (tick_1s !== 1'b1 || {hour, min, sec} !== 24'h115959 || pm !== 1'b1) begin errors++; $display("FAIL wrap_tick1 got t=%b %h pm=%b want 1 115959 1", tick_1s, {hour, min, sec}, pm); end
        cyc(4);
        checks++; if (tick_1s !== 1'b1 || {hour, min, sec} !== 24'h120000 || pm !== 1'b0) begin errors++; $display("FAIL wrap_tick2 got t=%b %h pm=%b want 1 120000 0", tick_1s, {hour, min, sec}, pm); end
        mode_12h = 1'b0; #1;
        checks++; if (hour !== 8'h00) begin errors++; $display("FAIL wrap_24h_view got %h want 00", hour); end
        @(negedge clk);
    endtask

    task automatic test_rollover;
        logic [7:0] hin [9] = '{8'h00, 8'h01, 8'h11, 8'h12, 8'h13, 8'h19, 8'h20, 8'h22, 8'h23};
        logic [7:0] hexp[9] = '{8'h12, 8'h01, 8'h11, 8'h12, 8'h01, 8'h07, 8'h08, 8'h10, 8'h11};
        logic       pexp[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_load(8'h09, 8'h59, 8'h59);
        cyc(4);
        checks++; if ({hour, min, sec} !== 24'h100000) begin errors++; $display("FAIL roll_09_10 got %h want 100000", {hour, min, sec}); end
        do_load(8'h19, 8'h59, 8'h59);
        cyc(4);
        checks++; if ({hour, min, sec} !== 24'h200000) begin errors++; $display("FAIL roll_19_20 got %h want 200000", {hour, min, sec}); end
        mode_12h = 1'b1;
        for (int k = 0; k < 9; k++) begin
            do_load(hin[k], 8'h00, 8'h00);
            checks++; if (hour !== hexp[k] || pm !== pexp[k]) begin errors++; $display("FAIL conv12_%h got %h pm=%b want %h pm=%b", hin[k], hour, pm, hexp[k], pexp[k]); end
        end
        mode_12h = 1'b0;
    endtask

    task automatic test_invalid;
        do_load(8'h10, 8'h20, 8'h30);
        set_hour = 8'h24; set_load = 1'b1;
        cyc(1); set_load = 1'b0;
        checks++; if (set_err !== 1'b1 || {hour, min, sec} !== 24'h102030) begin errors++; $display("FAIL inv_hour got err=%b %h want 1 102030", set_err, {hour, min, sec}); end
        cyc(1);
        checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL inv_err_pulse got %b want 0", set_err); end
        cyc(1);
        set_hour = 8'h10; set_min = 8'h5A; set_sec = 8'h30; set_load = 1'b1;
        cyc(1); set_load = 1'b0;
        checks++; if (set_err !== 1'b1 || tick_1s !== 1'b1 || {hour, min, sec} !== 24'h102031) begin errors++; $display("FAIL inv_min_wrap got err=%b t=%b %h want 1 1 102031", set_err, tick_1s, {hour, min, sec}); end
        cyc(1);
        checks++; if (set_err !== 1'b0 || tick_1s !== 1'b0) begin errors++; $display("FAIL inv_after got err=%b t=%b want 0 0", set_err, tick_1s); end
        cyc(3);
        checks++; if (tick_1s !== 1'b1 || sec !== 8'h32) begin errors++; $display("FAIL inv_phase got t=%b sec=%h want 1 32", tick_1s, sec); end
        set_hour = 8'h1A; set_min = 8'h00; set_sec = 8'h00; set_load = 1'b1;
        cyc(1); set_load = 1'b0;
        checks++; if (set_err !== 1'b1 || {hour, min} !== 16'h1020) begin errors++; $display("FAIL inv_nibble got err=%b %h want 1 1020", set_err, {hour, min}); end
    endtask

    task automatic test_collision;
        do_load(8'h01, 8'h02, 8'h03);
        cyc(3);
        do_load(8'h05, 8'h06, 8'h07);
        checks++; if (tick_1s !== 1'b0 || {hour, min, sec} !== 24'h050607) begin errors++; $display("FAIL coll_load got t=%b %h want 0 050607", tick_1s, {hour, min, sec}); end
        cyc(3);
        checks++; if (tick_1s !== 1'b0) begin errors++; $display("FAIL coll_tick_early got %b want 0", tick_1s); end
        cyc(1);
        checks++; if (tick_1s !== 1'b1 || sec !== 8'h08) begin errors++; $display("FAIL coll_next_tick got t=%b sec=%h want 1 08", tick_1s, sec); end
    endtask

    task automatic test_alarm;
        logic bad;
        alarm_en = 2'b11;
        do_load(8'h07, 8'h29, 8'h59);
        cyc(4);
        checks++; if (tick_1s !== 1'b1 || ring !== 2'b00 || {hour, min, sec} !== 24'h073000) begin errors++; $display("FAIL al_match_tick got t=%b ring=%b %h want 1 00 073000", tick_1s, ring, {hour, min, sec}); end
        cyc(1);
        checks++; if (ring !== 2'b01) begin errors++; $display("FAIL al_rise got %b want 01", ring); end
        cyc(11);
        checks++; if (ring !== 2'b01 || tick_1s !== 1'b1 || sec !== 8'h03) begin errors++; $display("FAIL al_last_tick got ring=%b t=%b sec=%h want 01 1 03", ring, tick_1s, sec); end
        cyc(1);
        checks++; if (ring !== 2'b00) begin errors++; $display("FAIL al_timeout got %b want 00", ring); end
        do_load(8'h07, 8'h30, 8'h00);
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin @(negedge clk); if (ring !== 2'b00) bad = 1'b1; end
        checks++; if (bad) begin errors++; $display("FAIL al_load_nomatch got ring set want 00"); end
        do_load(8'h07, 8'h29, 8'h59);
        cyc(5);
        checks++; if (ring !== 2'b01) begin errors++; $display("FAIL al_rise2 got %b want 01", ring); end
        stop = 1'b1; cyc(1); stop = 1'b0;
        checks++; if (ring !== 2'b00) begin errors++; $display("FAIL al_stop got %b want 00", ring); end
        do_load(8'h07, 8'h29, 8'h59);
        cyc(5);
        alarm_en = 2'b10; cyc(1);
        checks++; if (ring !== 2'b00) begin errors++; $display("FAIL al_disable got %b want 00", ring); end
        alarm_en = 2'b11;
    endtask

    task automatic test_snooze;
        logic bad;
        do_load(8'h07, 8'h29, 8'h59);
        cyc(5);
        snooze = 1'b1; cyc(1);
        checks++; if (ring !== 2'b00) begin errors++; $display("FAIL sn_enter got %b want 00", ring); end
        cyc(1); snooze = 1'b0;
        cyc(237);
        checks++; if (ring !== 2'b00) begin errors++; $display("FAIL sn_early got %b want 00", ring); end
        cyc(1);
        checks++; if (ring !== 2'b01) begin errors++; $display("FAIL sn_rering got %b want 01", ring); end
        snooze = 1'b1; stop = 1'b1; cyc(1); snooze = 1'b0; stop = 1'b0;
        checks++; if (ring !== 2'b00) begin errors++; $display("FAIL sn_stop_wins got %b want 00", ring); end
        bad = 1'b0;
        for (int k = 0; k < 260; k++) begin @(negedge clk); if (ring !== 2'b00) bad = 1'b1; end
        checks++; if (bad) begin errors++; $display("FAIL sn_no_rering got ring set want 00"); end
    endtask

    task automatic test_reset_mid;
        logic bad;
        do_load(8'h07, 8'h29, 8'h59);
        cyc(5);
        snooze = 1'b1; cyc(1); snooze = 1'b0;
        cyc(5);
        #2 rst_n = 1'b0; #1;
        checks++; if ({hour, min, sec} !== 24'h000000 || {tick_1s, ring, set_err} !== 4'b0) begin errors++; $display("FAIL rst_mid got %h flags=%b want 000000 0000", {hour, min, sec}, {tick_1s, ring, set_err}); end
        @(negedge clk); rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 280; k++) begin @(negedge clk); if (ring !== 2'b00) bad = 1'b1; end
        checks++; if (bad) begin errors++; $display("FAIL rst_no_ring got ring set want 00"); end
    endtask

    initial begin
        test_reset;
        test_wrap;
        test_rollover;
        test_invalid;
        test_collision;
        test_alarm;
        test_snooze;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_bcd_core.md
# rtc_bcd_core

Parametrised BCD real-time-clock core: divides `clk` down to a 1 Hz tick and keeps 24-hour hh:mm:ss time in packed BCD. It presents the time in either 24-hour or 12-hour form and drives N independent alarm channels, each with ring timeout, snooze and stop. It replaces the fixed single-alarm timekeeper and feeds the display mux and buzzer driver of the digital clock.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per second; ≥2; 4 for simulation.
- `N_ALARM`, 2: number of alarm channels; ≥1.
- `RING_SEC`, 60: seconds a channel rings before auto-clearing; ≥1.
- `SNOOZE_MIN`, 5: snooze length in minutes; ≥1.

Ports:
- `clk  in  1`: clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `set_load  in  1`: one-cycle pulse; load `set_hour/set_min/set_sec`.
- `set_hour  in  8`: BCD {tens, ones}, 24 h.
- `set_min  in  8`: BCD {tens, ones}.
- `set_sec  in  8`: BCD {tens, ones}.
- `mode_12h  in  1`: 1 = 12-hour display.
- `alarm_en  in  N_ALARM`: per-channel enable.
- `alarm_time  in  16*N_ALARM`: channel i at [16i+15:16i], {hour BCD8 (24 h), min BCD8}.
- `snooze  in  1`: pulse; snooze all ringing channels.
- `stop  in  1`: pulse; silence all channels.
- `hour  out  8`: BCD hour, 24 h or 12 h form.
- `min  out  8`: BCD minute.
- `sec  out  8`: BCD second.
- `pm  out  1`: internal hour ≥ 12.
- `tick_1s  out  1`: one-cycle pulse per second.
- `ring  out  N_ALARM`: channel ringing.
- `set_err  out  1`: one-cycle pulse; rejected load.

## Operation
- **Reset**
  - Time is 00:00:00; divider is 0.
  - `tick_1s`, `ring` and `set_err` are 0.
  - All alarm channels are IDLE.
  - `hour` reads 0x12 if `mode_12h`, else 0x00.
- **Divider**
  - Counter width is $clog2(TICK_DIV); it counts 0..TICK_DIV-1.
  - At TICK_DIV-1 the counter wraps and time advances by one second.
- **Time carry chain**
  - Seconds ones 9→0 carries to seconds tens; seconds tens 5→0 carries to minutes; minutes carry the same way.
  - Hour rolls 09→10, 19→20 and 23→00.
  - 23:59:59 advances to 00:00:00.
- **Load validation**
  - `set_load` is accepted only if every nibble ≤ 9, hour ≤ 0x23, min ≤ 0x59 and sec ≤ 0x59.
  - Accepted load: registers take the set values and the divider clears to 0.
  - Rejected load: nothing changes and `set_err` pulses.
- **12-hour display conversion** (combinational from the time registers; `mode_12h` takes effect immediately)
  - Internal hour 00 displays as 12.
  - Internal 01–11 and 12 display unchanged.
  - Internal 13–23 display as hour−12 in BCD.
  - `pm` = (internal hour ≥ 0x12) in both modes.
- **Per-channel FSM:** states IDLE, RING and SNOOZE, plus a seconds counter of width $clog2(SNOOZE_MIN*60+RING_SEC).
  - IDLE→RING: `tick_1s`-cycle with `alarm_en[i]`=1 and time == alarm hh:mm:00. Only counting ticks trigger; a load onto hh:mm:00 does not.
  - RING: counter increments per tick. After RING_SEC ticks → IDLE.
  - RING + `snooze` → SNOOZE, counter=0.
  - SNOOZE: after SNOOZE_MIN*60 ticks → RING, counter=0. Does not re-check the alarm time.
  - Any state + `stop` → IDLE. `stop` beats `snooze` in the same cycle.
  - `alarm_en[i]`=0 forces IDLE next cycle. It overrides the match and snooze expiry.
  - `snooze` in IDLE or SNOOZE is ignored.
  - A match while in RING or SNOOZE is ignored.
  - `ring[i]` = (state==RING), registered.
- `alarm_time` is not validated. An invalid value simply never matches.

## Timing
- **Tick timing**
  - The cycle in which the divider is at TICK_DIV-1 updates the time registers.
  - In the next cycle `tick_1s`=1 and `sec/min/hour` show the new time; both appear together.
  - Tick period is exactly TICK_DIV cycles, absent loads.
- **set_load**
  - Accepted: new time is visible the next cycle.
  - The first tick after load arrives TICK_DIV cycles after the load edge.
  - `set_err` is asserted the cycle after a rejected pulse.
- **set_load coincident with divider wrap**
  - The load wins; no increment occurs.
  - `tick_1s` stays 0 in the following cycle.
  - If the load is rejected, the increment and tick proceed normally.
- **Alarm latency**
  - `ring[i]` rises one cycle after the matching `tick_1s` pulse.
  - `ring[i]` falls one cycle after the expiring tick, after `stop`, or after `alarm_en` deassertion.
- **Other**
  - `snooze`/`stop` take effect on the next edge. Pulses longer than one cycle behave the same as one-cycle pulses.
  - Reset mid-ring or mid-snooze returns to the reset state immediately (asynchronous).

## Test plan
- **Wrap:** TICK_DIV=4, load 23:59:58 → ticks at load+4 and load+8 cycles; time 23:59:59 then 00:00:00. In 12 h mode `hour` reads 0x12 and `pm` goes 1→0.
- **Invalid load:** load hour=0x24, then min=0x5A → `set_err` pulses once each; time and tick phase unchanged.
- **Alarm:** ch0=07:30 enabled, load 07:29:59 → `ring[0]`=1 one cycle after the 07:30:00 tick. With RING_SEC=3, clears 3 ticks later. `ring[1]` stays 0. Load 07:30:00 directly → no ring.
- **Snooze:** SNOOZE_MIN=1. `snooze` while ringing → `ring`=0, re-rises 60 ticks later. `snooze`+`stop` in the same cycle → IDLE, no re-ring.
- **Load/tick collision:** `set_load` on the wrap cycle → no `tick_1s`, loaded time exact, next tick 4 cycles later.
- **Reset:** `rst_n` low mid-snooze → all outputs at reset values immediately. Still no ring after the snooze interval.
